cache_sram: RTL and testbench

Storage and sequencing primitives for the direct-mapped instruction cache. The block comprises three modules:
- `CACHE_SRAM`: single-port, synchronous-read SRAM model used as the tag/valid/data array.
- `D_FF`: enabled register with asynchronous reset.
- `COUNTER`: saturating up-counter with a sticky done flag, which sequences post-reset row clearing.

The cache controller instantiates all three.

---
 rtl/cache_sram_pkg.sv | 7 +
 rtl/cache_sram_counter.sv | 32 +++
 rtl/cache_sram_dff.sv | 24 ++
 rtl/cache_sram.sv | 46 ++++
 tb/tb_cache_sram.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/cache_sram_pkg.sv
// Shared constants for the instruction-cache storage primitives.
package cache_sram_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/cache_sram_counter.sv
// Saturating up-counter with a sticky done flag, used to walk rows after reset.
module cache_sram_counter
  import cache_sram_pkg::*;
#(
  parameter int                DWidth = 32,
  parameter logic [DWidth-1:0] RValue = '0,
  parameter logic [DWidth-1:0] FValue = '1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cnt_en_i,
  output logic              cnt_done_o,
  output logic [DWidth-1:0] cnt_data_o
);

  localparam logic [DWidth-1:0] One = DWidth'(1);

  // Count up to FValue, then park there and latch done until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_data_o <= RValue;
      cnt_done_o <= FALSE;
    end else if (cnt_en_i == TRUE) begin
      if (cnt_data_o != FValue) begin
        cnt_data_o <= cnt_data_o + One;
      end else begin
        cnt_done_o <= TRUE;
      end
    end
  end

endmodule

// File: rtl/cache_sram_dff.sv
// Enabled register with asynchronous active-low reset to a parameterised value.
module cache_sram_dff
  import cache_sram_pkg::*;
#(
  parameter int                DWidth = 32,
  parameter logic [DWidth-1:0] RValue = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              write_en_i,
  input  logic [DWidth-1:0] write_data_i,
  output logic [DWidth-1:0] read_data_o
);

  // Load on enable, hold otherwise; reset wins immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_data_o <= RValue;
    end else if (write_en_i == TRUE) begin
      read_data_o <= write_data_i;
    end
  end

endmodule

// File: rtl/cache_sram.sv
// Single-port synchronous-read SRAM model for the cache tag/valid/data array.
// The array has no reset; the client clears rows by writing them.
module cache_sram
  import cache_sram_pkg::*;
#(
  parameter int Depth  = 128,
  parameter int DWidth = 32
) (
  input  logic                     clk_i,
  input  logic                     csb_i,
  input  logic                     web_i,
  input  logic                     oeb_i,
  input  logic [$clog2(Depth)-1:0] addr_i,
  input  logic [DWidth-1:0]        data_i,
  output logic [DWidth-1:0]        data_o
);

  logic [DWidth-1:0] mem [Depth];
  logic [DWidth-1:0] rd_latch;
  logic              rd_en;

  assign rd_en = !csb_i && web_i;

  // Selected write stores the row; reads never touch the array.
  always_ff @(posedge clk_i) begin
    if (!csb_i && !web_i) begin
      mem[addr_i] <= data_i;
    end
  end

  // Output latch captures the addressed row on a read edge. It powers up
  // undefined like the array, so its reset is held inactive.
  cache_sram_dff #(
    .DWidth (DWidth),
    .RValue ('0)
  ) u_rd_latch (
    .clk_i        (clk_i),
    .rst_ni       (TRUE),
    .write_en_i   (rd_en),
    .write_data_i (mem[addr_i]),
    .read_data_o  (rd_latch)
  );

  assign data_o = oeb_i ? '0 : rd_latch;

endmodule

// File: tb/tb_cache_sram.sv
// Directed bench for the SRAM model, its output register and the row counter.
module tb_cache_sram;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM, 128 x 56
  logic        csb, web, oeb;
  logic [6:0]  addr;
  logic [55:0] wdata, rdata;

  cache_sram #(.Depth(128), .DWidth(56)) u_sram (
    .clk_i  (clk),
    .csb_i  (csb),
    .web_i  (web),
    .oeb_i  (oeb),
    .addr_i (addr),
    .data_i (wdata),
    .data_o (rdata)
  );

  // Register with non-zero reset value
  logic        dff_rst_n, dff_en;
  logic [31:0] dff_d, dff_q;

  cache_sram_dff #(.DWidth(32), .RValue(32'h5)) u_dff (
    .clk_i        (clk),
    .rst_ni       (dff_rst_n),
    .write_en_i   (dff_en),
    .write_data_i (dff_d),
    .read_data_o  (dff_q)
  );

  // Row-clearing counter, self-disabling once done
  logic        cnt_rst_n, cnt_en, cnt_done;
  logic [29:0] cnt_q;

  assign cnt_en = !cnt_done;

  cache_sram_counter #(.DWidth(30), .RValue(30'd0), .FValue(30'd127)) u_cnt (
    .clk_i      (clk),
    .rst_ni     (cnt_rst_n),
    .cnt_en_i   (cnt_en),
    .cnt_done_o (cnt_done),
    .cnt_data_o (cnt_q)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [55:0] pat(input int a);
    return {1'b1, 27'(a), ~28'(a)};
  endfunction

  task automatic sram_write(input int a, input logic [55:0] d);
    csb = 1'b0; web = 1'b0; addr = 7'(a); wdata = d;
    tick();
    csb = 1'b1; web = 1'b1;
  endtask

  task automatic sram_read(input int a);
    csb = 1'b0; web = 1'b1; addr = 7'(a);
    tick();
    csb = 1'b1;
  endtask

  localparam logic [55:0] ValA = 56'hA5A5_1234_5678_9A;
  localparam logic [55:0] ValB = 56'h5A_5A5A_0F0F_F0F0;
  localparam logic [55:0] ValC = 56'hC0FF_EE00_1122_33;
  localparam logic [55:0] ValD = 56'h00_0D0D_BEEF_CAFE;

  initial begin
    csb = 1'b1; web = 1'b1; oeb = 1'b0; addr = '0; wdata = '0;
    dff_rst_n = 1'b0; dff_en = 1'b0; dff_d = '0;
    cnt_rst_n = 1'b0;

    // ---------------- D_FF ----------------
    tick();
    check("dff_in_reset", 64'(dff_q), 64'h5);
    dff_rst_n = 1'b1;
    tick();
    check("dff_after_release", 64'(dff_q), 64'h5);
    dff_en = 1'b1; dff_d = 32'hDEADBEEF;
    tick();
    check("dff_load", 64'(dff_q), 64'hDEADBEEF);
    dff_en = 1'b0; dff_d = 32'h0000_1111;
    tick();
    tick();
    check("dff_hold", 64'(dff_q), 64'hDEADBEEF);
    #2 dff_rst_n = 1'b0;
    #1 check("dff_async_reset", 64'(dff_q), 64'h5);
    #1 dff_rst_n = 1'b1;
    tick();
    check("dff_reset_persists", 64'(dff_q), 64'h5);

    // ---------------- COUNTER ----------------
    check("cnt_reset_val", 64'(cnt_q), 64'd0);
    check("cnt_reset_done", 64'(cnt_done), 64'd0);
    cnt_rst_n = 1'b1;
    #1;
    for (int i = 0; i < 128; i++) begin
      check($sformatf("cnt_val_%0d", i), 64'(cnt_q), 64'(i));
      check($sformatf("cnt_done_%0d", i), 64'(cnt_done), 64'd0);
      tick();
    end
    check("cnt_done_set", 64'(cnt_done), 64'd1);
    check("cnt_saturated", 64'(cnt_q), 64'd127);
    tick();
    tick();
    check("cnt_done_sticky", 64'(cnt_done), 64'd1);
    check("cnt_no_wrap", 64'(cnt_q), 64'd127);
    #2 cnt_rst_n = 1'b0;
    #1 check("cnt_async_reset_val", 64'(cnt_q), 64'd0);
    check("cnt_async_reset_done", 64'(cnt_done), 64'd0);
    cnt_rst_n = 1'b1;
    tick();
    tick();
    check("cnt_restart", 64'(cnt_q), 64'd2);

    // ---------------- SRAM full sweep ----------------
    for (int a = 0; a < 128; a++) sram_write(a, pat(a));
    for (int a = 0; a < 128; a++) begin
      sram_read(a);
      check($sformatf("sram_row_%0d", a), 64'(rdata), 64'(pat(a)));
    end

    // ---------------- Write leaves latch, deselect holds ----------------
    sram_write(5, ValA);
    sram_read(5);
    check("rd5_after_write", 64'(rdata), 64'(ValA));
    sram_write(6, ValB);
    check("latch_held_on_write", 64'(rdata), 64'(ValA));
    csb = 1'b1; web = 1'b1; addr = 7'd6;
    tick();
    check("latch_held_deselect", 64'(rdata), 64'(ValA));
    csb = 1'b1; web = 1'b0; addr = 7'd6; wdata = ValC;
    tick();
    web = 1'b1;
    check("latch_held_desel_wr", 64'(rdata), 64'(ValA));
    sram_read(6);
    check("desel_write_ignored", 64'(rdata), 64'(ValB));

    // ---------------- Output enable gating ----------------
    oeb = 1'b1;
    sram_read(5);
    check("oeb_high_zero", 64'(rdata), 64'd0);
    oeb = 1'b0;
    #1 check("oeb_low_shows_latch", 64'(rdata), 64'(ValA));

    // ---------------- Address boundary ----------------
    sram_write(127, ValC);
    sram_write(0, ValD);
    sram_read(127);
    check("row127_no_alias", 64'(rdata), 64'(ValC));
    sram_read(0);
    check("row0_no_alias", 64'(rdata), 64'(ValD));
    sram_read(1);
    check("row1_untouched", 64'(rdata), 64'(pat(1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
